interrupt_request_register: RTL and testbench

Interrupt Request Register (IRR) stage of the 8259A PIC. It samples the eight IR input lines and latches them per the triggering mode in ICW1.LTIM. It combines the latched requests with the IMR output to produce masked pending requests for the priority resolver and an INT request to the control logic. Acknowledged levels are cleared on control-logic command, and the raw IRR can be placed on the internal data bus on an OCW3 read.

---
 rtl/interrupt_request_register_if.sv | 24 ++
 rtl/interrupt_request_register.sv | 71 +++++++
 tb/tb_interrupt_request_register.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_request_register_if.sv
// Request/mask/acknowledge signal group between the 8259A control logic and the IRR stage.
// The control side uses master; the IRR stage uses slave.
interface interrupt_request_register_if;
  logic [7:0] IR;
  logic       LTIM;
  logic [7:0] IMR_reg;
  logic       freeze;
  logic       ackValid;
  logic [2:0] ackLevel;
  logic       readIRR;
  logic [7:0] IRR_reg;
  logic [7:0] maskedReq;
  logic       INT_req;

  modport master (
    output IR, LTIM, IMR_reg, freeze, ackValid, ackLevel, readIRR,
    input  IRR_reg, maskedReq, INT_req
  );

  modport slave (
    input  IR, LTIM, IMR_reg, freeze, ackValid, ackLevel, readIRR,
    output IRR_reg, maskedReq, INT_req
  );
endinterface

// File: rtl/interrupt_request_register.sv
// 8259A IRR stage: latches IR per LTIM, masks with IMR, ack clears; IRR_SYNC_EN adds a 2-flop IR synchronizer.
// IR->IRR 2 edges (3 with IRR_SYNC_EN), INT_req one edge later; no backpressure, ack wins over set.
module interrupt_request_register (
  input  logic                               clk,
  input  logic                               reset_n,
  interrupt_request_register_if.slave        bus,
  output wire  [7:0]                         dataBuffer
);

  logic [7:0] ir_in;

`ifdef IRR_SYNC_EN
  logic [7:0] ir_sync_q;
  logic [7:0] ir_sync_d;

  always_comb ir_sync_d = bus.IR;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ir_sync_q <= 8'h00;
    else          ir_sync_q <= ir_sync_d;
  end

  assign ir_in = ir_sync_q;
`else
  assign ir_in = bus.IR;
`endif

  logic [7:0] ir_sample_q, ir_sample_d;
  logic [7:0] ir_prev_q, ir_prev_d;
  logic [7:0] irr_q, irr_d;
  logic [7:0] rise;
  logic [7:0] masked;
  logic       int_q, int_d;

  always_comb begin
    ir_sample_d = ir_in;
    ir_prev_d   = ir_sample_q;
    rise        = ir_sample_q & ~ir_prev_q;

    // Edge mode keeps a bit only while the line is still high after its rising edge.
    if (bus.freeze)    irr_d = irr_q;
    else if (bus.LTIM) irr_d = ir_sample_q;
    else               irr_d = (irr_q | rise) & ir_sample_q;

    if (bus.ackValid) irr_d[bus.ackLevel] = 1'b0;

    masked = irr_q & ~bus.IMR_reg;
    int_d  = |masked;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_sample_q <= 8'h00;
      ir_prev_q   <= 8'h00;
      irr_q       <= 8'h00;
      int_q       <= 1'b0;
    end else begin
      ir_sample_q <= ir_sample_d;
      ir_prev_q   <= ir_prev_d;
      irr_q       <= irr_d;
      int_q       <= int_d;
    end
  end

  assign bus.IRR_reg   = irr_q;
  assign bus.maskedReq = masked;
  assign bus.INT_req   = int_q;

  assign dataBuffer = bus.readIRR ? irr_q : 8'bz;

endmodule

// File: tb/tb_interrupt_request_register.sv
// Bench for interrupt_request_register: directed scenarios plus randomized traffic against a rule-level model.
module tb_interrupt_request_register;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  interrupt_request_register_if bus();
  wire [7:0] data_buffer;

  interrupt_request_register dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .dataBuffer (data_buffer)
  );

  int checks = 0;
  int fails  = 0;

  // Model state: what the IR lines looked like at the last two edges, and the pending set.
  logic [7:0] m_samp, m_prev, m_irr;
  logic       m_int;

  function automatic logic [16:0] model_out();
    return {m_irr, m_irr & ~bus.IMR_reg, m_int};
  endfunction

  function automatic logic [16:0] dut_out();
    return {bus.IRR_reg, bus.maskedReq, bus.INT_req};
  endfunction

  task automatic model_clear();
    m_samp = 8'h00;
    m_prev = 8'h00;
    m_irr  = 8'h00;
    m_int  = 1'b0;
  endtask

  // One clock: apply the pending-request rules to the inputs seen at this edge.
  task automatic tick();
    logic [7:0] nxt;
    logic       nint;
    @(posedge clk);
    if (!reset_n) begin
      model_clear();
    end else begin
      nint = (m_irr & ~bus.IMR_reg) != 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (bus.ackValid && (int'(bus.ackLevel) == i)) nxt[i] = 1'b0;
        else if (bus.freeze)                           nxt[i] = m_irr[i];
        else if (bus.LTIM)                             nxt[i] = m_samp[i];
        else if (m_samp[i] && !m_prev[i])              nxt[i] = 1'b1;
        else if (!m_samp[i])                           nxt[i] = 1'b0;
        else                                           nxt[i] = m_irr[i];
      end
      m_prev = m_samp;
      m_samp = bus.IR;
      m_irr  = nxt;
      m_int  = nint;
    end
    #1;
  endtask

  task automatic test_reset();
    bus.IR = 8'h00; bus.LTIM = 1'b0; bus.IMR_reg = 8'h00; bus.freeze = 1'b0;
    bus.ackValid = 1'b0; bus.ackLevel = 3'd0; bus.readIRR = 1'b1;
    reset_n = 1'b0;
    model_clear();
    tick(); tick();
    checks++;
    if (dut_out() !== 17'h0) begin
      fails++; $display("FAIL reset_outputs got=%h want=%h", dut_out(), 17'h0);
    end
    checks++;
    if (data_buffer !== 8'h00) begin
      fails++; $display("FAIL reset_databuf got=%h want=00", data_buffer);
    end
    bus.readIRR = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_edge();
    bus.LTIM = 1'b0; bus.IMR_reg = 8'h00; bus.IR = 8'h04;
    tick();
    checks++;
    if (bus.IRR_reg !== 8'h00) begin fails++; $display("FAIL edge_e0 got=%h want=00", bus.IRR_reg); end
    tick();
    checks++;
    if (bus.IRR_reg !== 8'h04 || bus.maskedReq !== 8'h04 || bus.INT_req !== 1'b0) begin
      fails++; $display("FAIL edge_e1 irr=%h mreq=%h int=%b want 04 04 0", bus.IRR_reg, bus.maskedReq, bus.INT_req);
    end
    tick();
    checks++;
    if (bus.INT_req !== 1'b1) begin fails++; $display("FAIL edge_int_e2 got=%b want=1", bus.INT_req); end
    bus.ackValid = 1'b1; bus.ackLevel = 3'd2;
    tick();
    bus.ackValid = 1'b0;
    checks++;
    if (bus.IRR_reg !== 8'h00) begin fails++; $display("FAIL edge_ack got=%h want=00", bus.IRR_reg); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.IRR_reg !== 8'h00 || dut_out() !== model_out()) begin
        fails++; $display("FAIL edge_hold_after_ack cyc=%0d got=%h want=%h", k, dut_out(), model_out());
      end
    end
    bus.IR = 8'h00;
    tick(); tick();
  endtask

  task automatic test_level();
    bus.LTIM = 1'b1; bus.IR = 8'h81;
    tick(); tick(); tick();
    checks++;
    if (bus.IRR_reg !== 8'h81) begin fails++; $display("FAIL level_load got=%h want=81", bus.IRR_reg); end
    bus.ackValid = 1'b1; bus.ackLevel = 3'd7;
    tick();
    bus.ackValid = 1'b0;
    checks++;
    if (bus.IRR_reg !== 8'h01) begin fails++; $display("FAIL level_ack got=%h want=01", bus.IRR_reg); end
    tick();
    checks++;
    if (bus.IRR_reg !== 8'h81) begin fails++; $display("FAIL level_reload got=%h want=81", bus.IRR_reg); end
    bus.IR = 8'h00;
    tick(); tick();
    checks++;
    if (bus.IRR_reg !== 8'h00 || dut_out() !== model_out()) begin
      fails++; $display("FAIL level_follow_low got=%h want=%h", dut_out(), model_out());
    end
    bus.LTIM = 1'b0;
    tick(); tick();
  endtask

  task automatic test_mask();
    bus.IMR_reg = 8'hFF; bus.IR = 8'h10;
    tick(); tick(); tick();
    checks++;
    if (bus.IRR_reg !== 8'h10 || bus.maskedReq !== 8'h00 || bus.INT_req !== 1'b0) begin
      fails++; $display("FAIL mask_latched irr=%h mreq=%h int=%b want 10 00 0", bus.IRR_reg, bus.maskedReq, bus.INT_req);
    end
    bus.IMR_reg = 8'hEF;
    #1;
    checks++;
    if (bus.maskedReq !== 8'h10 || bus.INT_req !== 1'b0) begin
      fails++; $display("FAIL unmask_immediate mreq=%h int=%b want 10 0", bus.maskedReq, bus.INT_req);
    end
    tick();
    checks++;
    if (bus.INT_req !== 1'b1) begin fails++; $display("FAIL unmask_int got=%b want=1", bus.INT_req); end
    bus.IR = 8'h00; bus.IMR_reg = 8'h00;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (dut_out() !== 17'h0) begin fails++; $display("FAIL mask_drain got=%h want=0", dut_out()); end
  endtask

  task automatic test_freeze();
    bus.freeze = 1'b1; bus.IR = 8'h08;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.IRR_reg !== 8'h00) begin fails++; $display("FAIL freeze_no_set cyc=%0d got=%h want=00", k, bus.IRR_reg); end
    end
    bus.freeze = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (bus.IRR_reg !== 8'h00) begin fails++; $display("FAIL freeze_edge_lost got=%h want=00", bus.IRR_reg); end
    bus.IR = 8'h00; tick(); tick();
    bus.IR = 8'h08; tick(); tick();
    checks++;
    if (bus.IRR_reg !== 8'h08) begin fails++; $display("FAIL freeze_fresh_edge got=%h want=08", bus.IRR_reg); end
    bus.freeze = 1'b1; bus.IR = 8'h00;
    tick(); tick(); tick();
    checks++;
    if (bus.IRR_reg !== 8'h08) begin fails++; $display("FAIL freeze_hold got=%h want=08", bus.IRR_reg); end
    bus.freeze = 1'b0;
    tick();
    checks++;
    if (bus.IRR_reg !== 8'h00 || dut_out() !== model_out()) begin
      fails++; $display("FAIL freeze_release_clear got=%h want=%h", dut_out(), model_out());
    end
  endtask

  task automatic test_read();
    bus.IR = 8'h5A;
    tick(); tick(); tick();
    bus.readIRR = 1'b1;
    #1;
    checks++;
    if (data_buffer !== 8'h5A) begin fails++; $display("FAIL read_drive got=%h want=5a", data_buffer); end
    bus.readIRR = 1'b0;
    #1;
    checks++;
    if (data_buffer === 8'h5A) begin fails++; $display("FAIL read_release got=%h want=not driven", data_buffer); end
    bus.IR = 8'h00;
    tick(); tick();
  endtask

  task automatic test_ack_vs_rise();
    bus.IR = 8'h02;
    tick();
    bus.ackValid = 1'b1; bus.ackLevel = 3'd1;
    tick();
    bus.ackValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.IRR_reg[1] !== 1'b0) begin fails++; $display("FAIL ack_beats_rise cyc=%0d got=%h want bit1=0", k, bus.IRR_reg); end
      tick();
    end
    bus.IR = 8'h00;
    tick(); tick();
  endtask

  task automatic test_async_reset();
    bus.IR = 8'hFF;
    tick(); tick(); tick();
    checks++;
    if (bus.IRR_reg !== 8'hFF || bus.INT_req !== 1'b1) begin
      fails++; $display("FAIL areset_setup irr=%h int=%b want ff 1", bus.IRR_reg, bus.INT_req);
    end
    #2 reset_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (bus.IRR_reg !== 8'h00 || bus.INT_req !== 1'b0 || bus.maskedReq !== 8'h00) begin
      fails++; $display("FAIL areset_immediate irr=%h int=%b mreq=%h want 00 0 00", bus.IRR_reg, bus.INT_req, bus.maskedReq);
    end
    tick();
    reset_n = 1'b1;
    tick(); tick();
    checks++;
    if (bus.IRR_reg !== 8'hFF || dut_out() !== model_out()) begin
      fails++; $display("FAIL areset_high_at_release got=%h want=%h", dut_out(), model_out());
    end
    bus.IR = 8'h00;
    tick(); tick(); tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      bus.IR       = bus.IR ^ (8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 31) == 0) bus.LTIM = ~bus.LTIM;
      if ($urandom_range(0, 7) == 0)  bus.IMR_reg = 8'($urandom) & 8'($urandom);
      bus.freeze   = ($urandom_range(0, 7) == 0);
      bus.ackValid = ($urandom_range(0, 3) == 0);
      bus.ackLevel = 3'($urandom_range(0, 7));
      bus.readIRR  = ($urandom_range(0, 1) == 1);
      tick();
      checks++;
      if (dut_out() !== model_out()) begin
        fails++; $display("FAIL random_outputs cyc=%0d got=%h want=%h", k, dut_out(), model_out());
      end
      if (bus.readIRR) begin
        checks++;
        if (data_buffer !== m_irr) begin
          fails++; $display("FAIL random_databuf cyc=%0d got=%h want=%h", k, data_buffer, m_irr);
        end
      end
    end
    bus.freeze = 1'b0; bus.ackValid = 1'b0; bus.readIRR = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge();
    test_level();
    test_mask();
    test_freeze();
    test_read();
    test_ack_vs_rise();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
